// File: rtl/fpu_special_case_pipe.sv
// Two-stage IEEE-754 special-case unit: classifies operands, then decides whether
// special rules fully determine the result and emits result-assembly selects/flags.
`timescale 1ns/1ps
module fpu_special_case_pipe #(
    parameter int EXP_WIDTH  = 8,
    parameter int FRAC_WIDTH = 23,
    parameter int TAG_WIDTH  = 4
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [2:0]                        in_op,
    input  logic [EXP_WIDTH+FRAC_WIDTH:0]     in_a,
    input  logic [EXP_WIDTH+FRAC_WIDTH:0]     in_b,
    input  logic                              in_ftz,
    input  logic [TAG_WIDTH-1:0]              in_tag,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [2:0]                        out_class_a,
    output logic [2:0]                        out_class_b,
    output logic                              out_special,
    output logic [3:0]                        out_sign_sel,
    output logic [2:0]                        out_exp_sel,
    output logic [2:0]                        out_frac_msb_sel,
    output logic [2:0]                        out_frac_lsbs_sel,
    output logic                              out_invalid,
    output logic                              out_div_zero,
    output logic [TAG_WIDTH-1:0]              out_tag
);
    localparam int W = 1 + EXP_WIDTH + FRAC_WIDTH;

    localparam logic [2:0] CLS_NORMAL = 3'b000;
    localparam logic [2:0] CLS_SUB    = 3'b100;
    localparam logic [2:0] CLS_ZERO   = 3'b101;
    localparam logic [2:0] CLS_INF    = 3'b011;
    localparam logic [2:0] CLS_NAN    = 3'b010;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_MUL  = 3'd2;
    localparam logic [2:0] OP_DIV  = 3'd3;
    localparam logic [2:0] OP_SQRT = 3'd4;

    localparam logic [3:0] SGN_ZERO = 4'd0;
    localparam logic [3:0] SGN_ONE  = 4'd1;
    localparam logic [3:0] SGN_A    = 4'd2;
    localparam logic [3:0] SGN_B    = 4'd3;
    localparam logic [3:0] SGN_NB   = 4'd4;
    localparam logic [3:0] SGN_A_B  = 4'd5;

    // Selects packed as {sign[3:0], exp[2:0], msb[2:0], lsbs[2:0]}
    localparam logic [12:0] SEL_NAN    = {4'd0, 3'd1, 3'd1, 3'd0};
    localparam logic [12:0] SEL_RESULT = {4'd7, 3'd4, 3'd4, 3'd3};
    localparam logic [12:0] SEL_COPY_A = {4'd2, 3'd2, 3'd2, 3'd1};

    function automatic logic [2:0] classify(input logic [EXP_WIDTH-1:0] e,
                                            input logic [FRAC_WIDTH-1:0] f,
                                            input logic ftz);
        if (&e)
            return (|f) ? CLS_NAN : CLS_INF;
        else if (e == '0)
            return ((|f) && !ftz) ? CLS_SUB : CLS_ZERO;
        else
            return CLS_NORMAL;
    endfunction

    function automatic logic is_snan(input logic [EXP_WIDTH-1:0] e,
                                     input logic [FRAC_WIDTH-1:0] f);
        return (&e) && (|f) && !f[FRAC_WIDTH-1];
    endfunction

    function automatic logic [12:0] sel_inf(input logic [3:0] s);
        return {s, 3'd1, 3'd0, 3'd0};
    endfunction

    function automatic logic [12:0] sel_zero(input logic [3:0] s);
        return {s, 3'd0, 3'd0, 3'd0};
    endfunction

    function automatic logic [12:0] sel_copy_b(input logic [3:0] s);
        return {s, 3'd3, 3'd3, 3'd2};
    endfunction

    logic                 vld_p1_q, vld_p1_d;
    logic [2:0]           op_p1_q, op_p1_d;
    logic [TAG_WIDTH-1:0] tag_p1_q, tag_p1_d;
    logic                 sa_p1_q, sa_p1_d, sb_p1_q, sb_p1_d;
    logic [2:0]           cls_a_p1_q, cls_a_p1_d, cls_b_p1_q, cls_b_p1_d;
    logic                 snan_a_p1_q, snan_a_p1_d, snan_b_p1_q, snan_b_p1_d;

    logic                 vld_p2_q, vld_p2_d;
    logic [2:0]           cls_a_p2_q, cls_a_p2_d, cls_b_p2_q, cls_b_p2_d;
    logic                 special_p2_q, special_p2_d;
    logic [12:0]          sel_p2_q, sel_p2_d;
    logic                 invalid_p2_q, invalid_p2_d;
    logic                 div_zero_p2_q, div_zero_p2_d;
    logic [TAG_WIDTH-1:0] tag_p2_q, tag_p2_d;

    logic s2_ready;
    logic load_p1, load_p2;

    assign s2_ready = ~vld_p2_q | out_ready;
    assign in_ready = ~vld_p1_q | s2_ready;
    assign load_p1  = in_ready & in_valid;
    assign load_p2  = s2_ready & vld_p1_q;

    // ---- stage 0 -> 1: operand classification ----
    always_comb begin
        vld_p1_d    = in_ready ? in_valid : vld_p1_q;
        op_p1_d     = op_p1_q;
        tag_p1_d    = tag_p1_q;
        sa_p1_d     = sa_p1_q;
        sb_p1_d     = sb_p1_q;
        cls_a_p1_d  = cls_a_p1_q;
        cls_b_p1_d  = cls_b_p1_q;
        snan_a_p1_d = snan_a_p1_q;
        snan_b_p1_d = snan_b_p1_q;
        if (load_p1) begin
            op_p1_d     = in_op;
            tag_p1_d    = in_tag;
            sa_p1_d     = in_a[W-1];
            sb_p1_d     = in_b[W-1];
            cls_a_p1_d  = classify(in_a[W-2 -: EXP_WIDTH], in_a[FRAC_WIDTH-1:0], in_ftz);
            cls_b_p1_d  = classify(in_b[W-2 -: EXP_WIDTH], in_b[FRAC_WIDTH-1:0], in_ftz);
            snan_a_p1_d = is_snan(in_a[W-2 -: EXP_WIDTH], in_a[FRAC_WIDTH-1:0]);
            snan_b_p1_d = is_snan(in_b[W-2 -: EXP_WIDTH], in_b[FRAC_WIDTH-1:0]);
        end
    end

    // ---- stage 1 -> 2: special-case decision ----
    logic        nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    logic        eff_b;
    logic [3:0]  sign_b_eff;
    logic        dec_special, dec_inv, dec_dz;
    logic [12:0] dec_sel;

    assign nan_a      = (cls_a_p1_q == CLS_NAN);
    assign nan_b      = (cls_b_p1_q == CLS_NAN);
    assign inf_a      = (cls_a_p1_q == CLS_INF);
    assign inf_b      = (cls_b_p1_q == CLS_INF);
    assign zero_a     = (cls_a_p1_q == CLS_ZERO);
    assign zero_b     = (cls_b_p1_q == CLS_ZERO);
    assign eff_b      = sb_p1_q ^ (op_p1_q == OP_SUB);
    assign sign_b_eff = (op_p1_q == OP_SUB) ? SGN_NB : SGN_B;

    always_comb begin
        dec_special = 1'b1;
        dec_sel     = SEL_RESULT;
        dec_inv     = 1'b0;
        dec_dz      = 1'b0;
        case (op_p1_q)
            OP_ADD, OP_SUB: begin
                if (nan_a || nan_b) begin
                    dec_sel = SEL_NAN;
                    dec_inv = snan_a_p1_q | snan_b_p1_q;
                end else if (inf_a && inf_b && (sa_p1_q != eff_b)) begin
                    dec_sel = SEL_NAN;
                    dec_inv = 1'b1;
                end else if (inf_a) begin
                    dec_sel = sel_inf(SGN_A);
                end else if (inf_b) begin
                    dec_sel = sel_inf(sign_b_eff);
                end else if (zero_a && zero_b) begin
                    dec_sel = sel_zero((sa_p1_q & eff_b) ? SGN_ONE : SGN_ZERO);
                end else if (zero_a) begin
                    dec_sel = sel_copy_b(sign_b_eff);
                end else if (zero_b) begin
                    dec_sel = SEL_COPY_A;
                end else begin
                    dec_special = 1'b0;
                end
            end
            OP_MUL: begin
                if (nan_a || nan_b) begin
                    dec_sel = SEL_NAN;
                    dec_inv = snan_a_p1_q | snan_b_p1_q;
                end else if ((inf_a && zero_b) || (zero_a && inf_b)) begin
                    dec_sel = SEL_NAN;
                    dec_inv = 1'b1;
                end else if (inf_a || inf_b) begin
                    dec_sel = sel_inf(SGN_A_B);
                end else if (zero_a || zero_b) begin
                    dec_sel = sel_zero(SGN_A_B);
                end else begin
                    dec_special = 1'b0;
                end
            end
            OP_DIV: begin
                if (nan_a || nan_b) begin
                    dec_sel = SEL_NAN;
                    dec_inv = snan_a_p1_q | snan_b_p1_q;
                end else if ((zero_a && zero_b) || (inf_a && inf_b)) begin
                    dec_sel = SEL_NAN;
                    dec_inv = 1'b1;
                end else if (inf_a) begin
                    dec_sel = sel_inf(SGN_A_B);
                end else if (inf_b || zero_a) begin
                    dec_sel = sel_zero(SGN_A_B);
                end else if (zero_b) begin
                    dec_sel = sel_inf(SGN_A_B);
                    dec_dz  = 1'b1;
                end else begin
                    dec_special = 1'b0;
                end
            end
            OP_SQRT: begin
                // B is never considered here, so its signalling bit cannot raise invalid
                if (nan_a) begin
                    dec_sel = SEL_NAN;
                    dec_inv = snan_a_p1_q;
                end else if (zero_a) begin
                    dec_sel = sel_zero(SGN_A);
                end else if (sa_p1_q) begin
                    dec_sel = SEL_NAN;
                    dec_inv = 1'b1;
                end else if (inf_a) begin
                    dec_sel = sel_inf(SGN_ZERO);
                end else begin
                    dec_special = 1'b0;
                end
            end
            default: dec_special = 1'b0;
        endcase
    end

    always_comb begin
        vld_p2_d      = s2_ready ? vld_p1_q : vld_p2_q;
        cls_a_p2_d    = cls_a_p2_q;
        cls_b_p2_d    = cls_b_p2_q;
        special_p2_d  = special_p2_q;
        sel_p2_d      = sel_p2_q;
        invalid_p2_d  = invalid_p2_q;
        div_zero_p2_d = div_zero_p2_q;
        tag_p2_d      = tag_p2_q;
        if (load_p2) begin
            cls_a_p2_d    = cls_a_p1_q;
            cls_b_p2_d    = cls_b_p1_q;
            special_p2_d  = dec_special;
            sel_p2_d      = dec_sel;
            invalid_p2_d  = dec_inv;
            div_zero_p2_d = dec_dz;
            tag_p2_d      = tag_p1_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1_q      <= 1'b0;
            op_p1_q       <= '0;
            tag_p1_q      <= '0;
            sa_p1_q       <= 1'b0;
            sb_p1_q       <= 1'b0;
            cls_a_p1_q    <= '0;
            cls_b_p1_q    <= '0;
            snan_a_p1_q   <= 1'b0;
            snan_b_p1_q   <= 1'b0;
            vld_p2_q      <= 1'b0;
            cls_a_p2_q    <= '0;
            cls_b_p2_q    <= '0;
            special_p2_q  <= 1'b0;
            sel_p2_q      <= '0;
            invalid_p2_q  <= 1'b0;
            div_zero_p2_q <= 1'b0;
            tag_p2_q      <= '0;
        end else begin
            vld_p1_q      <= vld_p1_d;
            op_p1_q       <= op_p1_d;
            tag_p1_q      <= tag_p1_d;
            sa_p1_q       <= sa_p1_d;
            sb_p1_q       <= sb_p1_d;
            cls_a_p1_q    <= cls_a_p1_d;
            cls_b_p1_q    <= cls_b_p1_d;
            snan_a_p1_q   <= snan_a_p1_d;
            snan_b_p1_q   <= snan_b_p1_d;
            vld_p2_q      <= vld_p2_d;
            cls_a_p2_q    <= cls_a_p2_d;
            cls_b_p2_q    <= cls_b_p2_d;
            special_p2_q  <= special_p2_d;
            sel_p2_q      <= sel_p2_d;
            invalid_p2_q  <= invalid_p2_d;
            div_zero_p2_q <= div_zero_p2_d;
            tag_p2_q      <= tag_p2_d;
        end
    end

    assign out_valid         = vld_p2_q;
    assign out_class_a       = cls_a_p2_q;
    assign out_class_b       = cls_b_p2_q;
    assign out_special       = special_p2_q;
    assign out_sign_sel      = sel_p2_q[12:9];
    assign out_exp_sel       = sel_p2_q[8:6];
    assign out_frac_msb_sel  = sel_p2_q[5:3];
    assign out_frac_lsbs_sel = sel_p2_q[2:0];
    assign out_invalid       = invalid_p2_q;
    assign out_div_zero      = div_zero_p2_q;
    assign out_tag           = tag_p2_q;

endmodule

// File: tb/tb_fpu_special_case_pipe.sv
// Directed bench for fpu_special_case_pipe: single and half precision instances,
// special-case vectors, back-pressure streaming and mid-stream reset.
`timescale 1ns/1ps
module tb_fpu_special_case_pipe;
    logic        clk;
    logic        reset_n;

    logic        in_valid, in_ready, in_ftz, out_valid, out_ready;
    logic [2:0]  in_op;
    logic [31:0] in_a, in_b;
    logic [3:0]  in_tag, out_tag;
    logic [2:0]  out_class_a, out_class_b, out_exp_sel, out_frac_msb_sel, out_frac_lsbs_sel;
    logic        out_special, out_invalid, out_div_zero;
    logic [3:0]  out_sign_sel;

    logic        h_in_valid, h_in_ready, h_in_ftz, h_out_valid, h_out_ready;
    logic [2:0]  h_in_op;
    logic [15:0] h_in_a, h_in_b;
    logic [3:0]  h_in_tag, h_out_tag;
    logic [2:0]  h_out_class_a, h_out_class_b, h_out_exp_sel, h_out_frac_msb_sel, h_out_frac_lsbs_sel;
    logic        h_out_special, h_out_invalid, h_out_div_zero;
    logic [3:0]  h_out_sign_sel;

    int n_cmp = 0;
    int n_err = 0;

    fpu_special_case_pipe #(.EXP_WIDTH(8), .FRAC_WIDTH(23), .TAG_WIDTH(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_ftz(in_ftz), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_class_a(out_class_a), .out_class_b(out_class_b),
        .out_special(out_special), .out_sign_sel(out_sign_sel),
        .out_exp_sel(out_exp_sel), .out_frac_msb_sel(out_frac_msb_sel),
        .out_frac_lsbs_sel(out_frac_lsbs_sel), .out_invalid(out_invalid),
        .out_div_zero(out_div_zero), .out_tag(out_tag)
    );

    fpu_special_case_pipe #(.EXP_WIDTH(5), .FRAC_WIDTH(10), .TAG_WIDTH(4)) dut_h (
        .clk(clk), .reset_n(reset_n),
        .in_valid(h_in_valid), .in_ready(h_in_ready), .in_op(h_in_op),
        .in_a(h_in_a), .in_b(h_in_b), .in_ftz(h_in_ftz), .in_tag(h_in_tag),
        .out_valid(h_out_valid), .out_ready(h_out_ready),
        .out_class_a(h_out_class_a), .out_class_b(h_out_class_b),
        .out_special(h_out_special), .out_sign_sel(h_out_sign_sel),
        .out_exp_sel(h_out_exp_sel), .out_frac_msb_sel(h_out_frac_msb_sel),
        .out_frac_lsbs_sel(h_out_frac_lsbs_sel), .out_invalid(h_out_invalid),
        .out_div_zero(h_out_div_zero), .out_tag(h_out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Offer one op with out_ready high and sample the descriptor two edges later
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic ftz, input logic [3:0] tag);
        @(negedge clk);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_ftz = ftz; in_tag = tag;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("valid", {31'd0, out_valid}, 32'd1);
        check_eq("tag", {28'd0, out_tag}, {28'd0, tag});
    endtask

    task automatic check_desc(input string name, input logic sp, input logic [3:0] sg,
                              input logic [2:0] ex, input logic [2:0] ms, input logic [2:0] ls,
                              input logic inv, input logic dz);
        check_eq({name, ".special"}, {31'd0, out_special}, {31'd0, sp});
        check_eq({name, ".sign"}, {28'd0, out_sign_sel}, {28'd0, sg});
        check_eq({name, ".exp"}, {29'd0, out_exp_sel}, {29'd0, ex});
        check_eq({name, ".msb"}, {29'd0, out_frac_msb_sel}, {29'd0, ms});
        check_eq({name, ".lsbs"}, {29'd0, out_frac_lsbs_sel}, {29'd0, ls});
        check_eq({name, ".invalid"}, {31'd0, out_invalid}, {31'd0, inv});
        check_eq({name, ".divzero"}, {31'd0, out_div_zero}, {31'd0, dz});
    endtask

    task automatic run_h(input logic [2:0] op, input logic [15:0] a, input string name,
                         input logic sp, input logic [3:0] sg, input logic inv);
        @(negedge clk);
        h_in_valid = 1'b1; h_in_op = op; h_in_a = a; h_in_b = 16'h3C00; h_in_ftz = 1'b0;
        @(negedge clk);
        h_in_valid = 1'b0;
        @(negedge clk);
        check_eq({name, ".valid"}, {31'd0, h_out_valid}, 32'd1);
        check_eq({name, ".special"}, {31'd0, h_out_special}, {31'd0, sp});
        check_eq({name, ".sign"}, {28'd0, h_out_sign_sel}, {28'd0, sg});
        check_eq({name, ".invalid"}, {31'd0, h_out_invalid}, {31'd0, inv});
    endtask

    int sent, rx, extra, stale;
    logic stall_seen;

    initial begin
        reset_n = 1'b1;
        in_valid = 0; in_op = 0; in_a = 0; in_b = 0; in_ftz = 0; in_tag = 0; out_ready = 1;
        h_in_valid = 0; h_in_op = 0; h_in_a = 0; h_in_b = 0; h_in_ftz = 0; h_in_tag = 0;
        h_out_ready = 1;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_eq("rst_special", {31'd0, out_special}, 32'd0);
        check_eq("rst_sign_sel", {28'd0, out_sign_sel}, 32'd0);
        reset_n = 1'b1;

        // inf x 0 -> NaN, invalid
        run_op(3'd2, 32'h7F800000, 32'h00000000, 1'b0, 4'd1);
        check_desc("mul_inf_zero", 1, 4'd0, 3'd1, 3'd1, 3'd0, 1, 0);
        check_eq("mul_cls_a", {29'd0, out_class_a}, 32'b011);
        check_eq("mul_cls_b", {29'd0, out_class_b}, 32'b101);
        // -1 / -0 -> Inf(sa^sb), div-by-zero
        run_op(3'd3, 32'hBF800000, 32'h80000000, 1'b0, 4'd2);
        check_desc("div_by_zero", 1, 4'd5, 3'd1, 3'd0, 3'd0, 0, 1);
        run_op(3'd0, 32'h80000000, 32'h80000000, 1'b0, 4'd3);
        check_desc("add_nz_nz", 1, 4'd1, 3'd0, 3'd0, 3'd0, 0, 0);
        run_op(3'd1, 32'h80000000, 32'h80000000, 1'b0, 4'd4);
        check_desc("sub_nz_nz", 1, 4'd0, 3'd0, 3'd0, 3'd0, 0, 0);
        // subnormal + 1.0 with and without flush-to-zero
        run_op(3'd0, 32'h00000001, 32'h3F800000, 1'b1, 4'd5);
        check_desc("add_ftz", 1, 4'd3, 3'd3, 3'd3, 3'd2, 0, 0);
        check_eq("add_ftz_cls_a", {29'd0, out_class_a}, 32'b101);
        run_op(3'd0, 32'h00000001, 32'h3F800000, 1'b0, 4'd6);
        check_desc("add_noftz", 0, 4'd7, 3'd4, 3'd4, 3'd3, 0, 0);
        check_eq("add_noftz_cls_a", {29'd0, out_class_a}, 32'b100);
        run_op(3'd0, 32'h7F800000, 32'hFF800000, 1'b0, 4'd7);
        check_desc("add_inf_minf", 1, 4'd0, 3'd1, 3'd1, 3'd0, 1, 0);
        run_op(3'd1, 32'h3F800000, 32'h7F800000, 1'b0, 4'd8);
        check_desc("sub_x_inf", 1, 4'd4, 3'd1, 3'd0, 3'd0, 0, 0);
        run_op(3'd0, 32'h7FC00000, 32'h3F800000, 1'b0, 4'd9);
        check_desc("add_qnan", 1, 4'd0, 3'd1, 3'd1, 3'd0, 0, 0);
        run_op(3'd4, 32'h7FA00000, 32'h00000000, 1'b0, 4'd10);
        check_desc("sqrt_snan", 1, 4'd0, 3'd1, 3'd1, 3'd0, 1, 0);
        run_op(3'd4, 32'hBF800000, 32'h00000000, 1'b0, 4'd11);
        check_desc("sqrt_neg", 1, 4'd0, 3'd1, 3'd1, 3'd0, 1, 0);
        check_eq("sqrt_cls_b", {29'd0, out_class_b}, 32'b101);
        run_op(3'd4, 32'h7F800000, 32'h7FA00000, 1'b0, 4'd12);
        check_desc("sqrt_pinf", 1, 4'd0, 3'd1, 3'd0, 3'd0, 0, 0);
        run_op(3'd3, 32'h80000000, 32'h00000000, 1'b0, 4'd13);
        check_desc("div_zero_zero", 1, 4'd0, 3'd1, 3'd1, 3'd0, 1, 0);
        run_op(3'd3, 32'h3F800000, 32'hFF800000, 1'b0, 4'd14);
        check_desc("div_x_inf", 1, 4'd5, 3'd0, 3'd0, 3'd0, 0, 0);
        run_op(3'd6, 32'h7F800000, 32'h00000000, 1'b0, 4'd15);
        check_desc("reserved_op", 0, 4'd7, 3'd4, 3'd4, 3'd3, 0, 0);

        run_h(3'd4, 16'hFC00, "h_sqrt_minf", 1, 4'd0, 1);
        run_h(3'd4, 16'h3D00, "h_sqrt_norm", 0, 4'd7, 0);

        // Back-pressure: 8 ops streamed, out_ready low on cycles 3..6
        sent = 0; rx = 0; extra = 0; stall_seen = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            out_ready = !(c >= 3 && c <= 6);
            in_valid = (sent < 8);
            in_op = 3'd2; in_a = 32'h3F800000; in_b = 32'h40000000; in_ftz = 1'b0;
            in_tag = sent[3:0];
            #1;
            if (in_valid && !in_ready) stall_seen = 1'b1;
            if (out_valid && out_ready) begin
                if (rx < 8) begin
                    check_eq("bp_tag", {28'd0, out_tag}, rx);
                    rx++;
                end else begin
                    extra++;
                end
            end
            if (in_valid && in_ready) sent++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check_eq("bp_stall_seen", {31'd0, stall_seen}, 32'd1);
        check_eq("bp_received", rx, 32'd8);
        check_eq("bp_extra", extra, 32'd0);

        // Mid-stream reset with a full, stalled pipeline
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_op = 3'd0; in_a = 32'h3F800000; in_b = 32'h3F800000;
            in_tag = 4'(9 + i);
        end
        @(negedge clk);
        check_eq("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check_eq("async_rst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        out_ready = 1'b1;
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check_eq("post_rst_stale", stale, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
